// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: register map offsets, CTRL field
// positions and the per-channel control flag bundle.
package timer_bank_pkg;

    localparam logic [3:0] OFS_RELOAD = 4'h0;
    localparam logic [3:0] OFS_COUNT  = 4'h4;
    localparam logic [3:0] OFS_CTRL   = 4'h8;
    localparam logic [3:0] OFS_STATUS = 4'hC;
    localparam int         CH_STRIDE  = 'h10;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_IE_BIT      = 1;
    localparam int CTRL_ONESHOT_BIT = 2;
    localparam int CTRL_PRESC_LSB   = 8;

    localparam logic [31:0] RDATA_UNMAPPED = 32'hcdcdcdcd;

    typedef enum logic [1:0] {
        REG_RELOAD = 2'd0,
        REG_COUNT  = 2'd1,
        REG_CTRL   = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    typedef struct packed {
        logic oneshot;
        logic ie;
        logic en;
    } ctrl_flags_t;

    // Maps the low nibble of a channel-relative offset to its register.
    // Misaligned offsets are rejected separately by the decoder.
    function automatic reg_sel_e reg_sel_of(input logic [3:0] ofs);
        reg_sel_e sel;
        case (ofs)
            OFS_RELOAD: sel = REG_RELOAD;
            OFS_COUNT:  sel = REG_COUNT;
            OFS_CTRL:   sel = REG_CTRL;
            OFS_STATUS: sel = REG_STATUS;
            default:    sel = reg_sel_e'(ofs[3:2]);
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One up-counting timer: prescaler, reload on overflow, one-shot disable and
// a sticky pending flag cleared by write-1.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_reload,
    input  logic               wr_count,
    input  logic               wr_ctrl,
    input  logic               wr_status,
    input  logic [CNT_W-1:0]   wr_cnt_val,
    input  ctrl_flags_t        wr_flags,
    input  logic [PRESC_W-1:0] wr_presc,
    input  logic               wr_clr,
    output logic [CNT_W-1:0]   reload,
    output logic [CNT_W-1:0]   count,
    output ctrl_flags_t        flags,
    output logic [PRESC_W-1:0] presc,
    output logic               pending
);

    logic [PRESC_W-1:0] pcnt;
    logic               tick;
    logic               overflow;
    logic               ovf_eff;

    // A COUNT write in the overflow cycle wins, so that overflow has no
    // side effects at all (no pending, no one-shot disable).
    always_comb begin
        tick     = flags.en && (pcnt == presc);
        overflow = tick && (count == {CNT_W{1'b1}});
        ovf_eff  = overflow && !wr_count;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
        end else if (wr_ctrl || !flags.en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload <= '0;
            count  <= '0;
        end else begin
            if (wr_reload) begin
                reload <= wr_cnt_val;
            end
            if (wr_count) begin
                count <= wr_cnt_val;
            end else if (overflow) begin
                count <= reload;
            end else if (tick) begin
                count <= count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= '0;
            presc <= '0;
        end else if (wr_ctrl) begin
            flags <= wr_flags;
            presc <= wr_presc;
        end else if (ovf_eff && flags.oneshot) begin
            flags.en <= 1'b0;
        end
    end

    // Setting by overflow takes priority over a simultaneous W1C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
        end else if (ovf_eff) begin
            pending <= 1'b1;
        end else if (wr_status && wr_clr) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/timer_bank.sv
// Memory-mapped bank of N_CH timers: address decode, per-channel write
// strobes, read mux, pending SUMMARY register and the shared irq line.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int          N_CH      = 4,
    parameter int          CNT_W     = 32,
    parameter int          PRESC_W   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        r_accessible,
    output logic        w_accessible
);

    localparam logic [31:0] SUMMARY_OFS = 32'(N_CH * CH_STRIDE);

    logic [31:0]        ofs;
    logic               ch_hit;
    logic               sum_hit;
    logic [2:0]         ch_idx;
    reg_sel_e           sel;

    logic [CNT_W-1:0]   wr_cnt_val;
    ctrl_flags_t        wr_flags;
    logic [PRESC_W-1:0] wr_presc;

    logic [CNT_W-1:0]   reload_a [N_CH];
    logic [CNT_W-1:0]   count_a  [N_CH];
    ctrl_flags_t        flags_a  [N_CH];
    logic [PRESC_W-1:0] presc_a  [N_CH];
    logic [N_CH-1:0]    pending_v;
    logic [N_CH-1:0]    ie_v;

    // Bit 31 is not decoded, so the subtraction is taken modulo 2^31.
    assign ofs     = (addr - BASE_ADDR) & 32'h7FFF_FFFF;
    assign ch_hit  = (ofs < SUMMARY_OFS) && (ofs[1:0] == 2'b00);
    assign sum_hit = (ofs == SUMMARY_OFS);
    assign ch_idx  = ofs[6:4];
    assign sel     = reg_sel_of(ofs[3:0]);

    assign wr_cnt_val       = wdata[CNT_W-1:0];
    assign wr_presc         = wdata[CTRL_PRESC_LSB +: PRESC_W];
    assign wr_flags.en      = wdata[CTRL_EN_BIT];
    assign wr_flags.ie      = wdata[CTRL_IE_BIT];
    assign wr_flags.oneshot = wdata[CTRL_ONESHOT_BIT];

    assign w_accessible = wr && ch_hit;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic ch_wr;
        assign ch_wr   = wr && ch_hit && (ch_idx == 3'(c));
        assign ie_v[c] = flags_a[c].ie;

        timer_channel #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .wr_reload  (ch_wr && (sel == REG_RELOAD)),
            .wr_count   (ch_wr && (sel == REG_COUNT)),
            .wr_ctrl    (ch_wr && (sel == REG_CTRL)),
            .wr_status  (ch_wr && (sel == REG_STATUS)),
            .wr_cnt_val (wr_cnt_val),
            .wr_flags   (wr_flags),
            .wr_presc   (wr_presc),
            .wr_clr     (wdata[0]),
            .reload     (reload_a[c]),
            .count      (count_a[c]),
            .flags      (flags_a[c]),
            .presc      (presc_a[c]),
            .pending    (pending_v[c])
        );
    end

    assign irq = |(pending_v & ie_v);

    always_comb begin
        rdata        = '0;
        r_accessible = 1'b0;
        if (rd) begin
            rdata = RDATA_UNMAPPED;
            if (sum_hit) begin
                r_accessible      = 1'b1;
                rdata             = '0;
                rdata[N_CH-1:0]   = pending_v;
            end else if (ch_hit) begin
                r_accessible = 1'b1;
                rdata        = '0;
                for (int c = 0; c < N_CH; c++) begin
                    if (ch_idx == 3'(c)) begin
                        case (sel)
                            REG_RELOAD: rdata[CNT_W-1:0] = reload_a[c];
                            REG_COUNT:  rdata[CNT_W-1:0] = count_a[c];
                            REG_CTRL: begin
                                rdata[CTRL_EN_BIT]               = flags_a[c].en;
                                rdata[CTRL_IE_BIT]               = flags_a[c].ie;
                                rdata[CTRL_ONESHOT_BIT]          = flags_a[c].oneshot;
                                rdata[CTRL_PRESC_LSB +: PRESC_W] = presc_a[c];
                            end
                            REG_STATUS: rdata[0] = pending_v[c];
                            default:    rdata    = '0;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: register access, overflow/reload, prescaler,
// one-shot, same-cycle priorities, SUMMARY/irq and asynchronous reset.
module tb_timer_bank;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] SUM  = BASE + 32'h40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    logic        r_accessible;
    logic        w_accessible;

    int          compared = 0;
    int          mismatched = 0;
    logic        last_wacc;
    logic [31:0] rv;
    logic        ra;

    timer_bank dut (
        .clk          (clk),
        .reset        (reset),
        .rd           (rd),
        .wr           (wr),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .irq          (irq),
        .r_accessible (r_accessible),
        .w_accessible (w_accessible)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_addr(input int ch, input logic [31:0] ofs);
        return BASE + 32'(16 * ch) + ofs;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write lands on the next posedge; returns 1ns after it.
    task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        #1 last_wacc = w_accessible;
        @(posedge clk);
        #1 wr = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v, output logic acc);
        addr = a;
        rd   = 1'b1;
        #1;
        v    = rdata;
        acc  = r_accessible;
        rd   = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        peek(a, rv, ra);
        check(tag, rv, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string phase);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                @(negedge clk);
                peek(reg_addr(c, 32'(4 * r)), rv, ra);
                check($sformatf("%s ch%0d reg%0d data", phase, c, r), rv, 32'h0);
                check($sformatf("%s ch%0d reg%0d acc", phase, c, r), 32'(ra), 32'h1);
            end
        end
        @(negedge clk);
        peek(SUM, rv, ra);
        check({phase, " summary"}, rv, 32'h0);
        check({phase, " irq"}, 32'(irq), 32'h0);
    endtask

    initial begin
        $display("[TB] start");
        #2 reset = 1'b0;
        #1;
        check("reset irq", 32'(irq), 32'h0);
        check("reset racc", 32'(r_accessible), 32'h0);
        check("reset wacc", 32'(w_accessible), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        check_all_zero("post reset");

        @(negedge clk);
        peek(BASE + 32'h100, rv, ra);
        check("unmapped data", rv, 32'hcdcdcdcd);
        check("unmapped acc", 32'(ra), 32'h0);
        addr = reg_addr(0, 32'h0);
        #1;
        check("idle rdata", rdata, 32'h0);
        check("idle racc", 32'(r_accessible), 32'h0);

        write_reg(SUM, 32'hF);
        check("summary write wacc", 32'(last_wacc), 32'h0);
        check_reg("summary after write", SUM, 32'h0);

        // ch0 overflow with reload and interrupt
        write_reg(reg_addr(0, 32'h0), 32'hFFFF_FFF0);
        check("reload wacc", 32'(last_wacc), 32'h1);
        peek(32'hC000_0000, rv, ra);
        check("bit31 alias reload", rv, 32'hFFFF_FFF0);
        write_reg(reg_addr(0, 32'h4), 32'hFFFF_FFFE);
        write_reg(reg_addr(0, 32'h8), 32'h3);
        check_reg("ch0 count e0", reg_addr(0, 32'h4), 32'hFFFF_FFFE);
        check("ch0 irq e0", 32'(irq), 32'h0);
        step(1);
        check_reg("ch0 count e1", reg_addr(0, 32'h4), 32'hFFFF_FFFF);
        check("ch0 irq e1", 32'(irq), 32'h0);
        step(1);
        check_reg("ch0 count reloaded", reg_addr(0, 32'h4), 32'hFFFF_FFF0);
        check("ch0 irq raised", 32'(irq), 32'h1);
        check_reg("ch0 status set", reg_addr(0, 32'hC), 32'h1);
        check_reg("ch0 status reread", reg_addr(0, 32'hC), 32'h1);
        write_reg(reg_addr(0, 32'hC), 32'h1);
        check("ch0 irq cleared", 32'(irq), 32'h0);
        check_reg("ch0 status cleared", reg_addr(0, 32'hC), 32'h0);
        write_reg(reg_addr(0, 32'h8), 32'h0);
        check_reg("ch0 count frozen", reg_addr(0, 32'h4), 32'hFFFF_FFF2);
        step(2);
        check_reg("ch0 count still frozen", reg_addr(0, 32'h4), 32'hFFFF_FFF2);

        // ch1 prescaler 3, one-shot
        write_reg(reg_addr(1, 32'h4), 32'hFFFF_FFFE);
        write_reg(reg_addr(1, 32'h8), 32'h305);
        check_reg("ch1 ctrl readback", reg_addr(1, 32'h8), 32'h305);
        step(3);
        check_reg("ch1 count before tick", reg_addr(1, 32'h4), 32'hFFFF_FFFE);
        step(1);
        check_reg("ch1 count first tick", reg_addr(1, 32'h4), 32'hFFFF_FFFF);
        step(3);
        check_reg("ch1 count before ovf", reg_addr(1, 32'h4), 32'hFFFF_FFFF);
        check_reg("ch1 status before ovf", reg_addr(1, 32'hC), 32'h0);
        step(1);
        check_reg("ch1 count reloaded", reg_addr(1, 32'h4), 32'h0);
        check_reg("ch1 en cleared", reg_addr(1, 32'h8), 32'h304);
        check_reg("ch1 status set", reg_addr(1, 32'hC), 32'h1);
        check("ch1 irq masked", 32'(irq), 32'h0);
        step(4);
        check_reg("ch1 count held", reg_addr(1, 32'h4), 32'h0);
        write_reg(reg_addr(1, 32'hC), 32'h1);
        check_reg("ch1 status cleared", reg_addr(1, 32'hC), 32'h0);

        // ch2 W1C coincident with overflow
        write_reg(reg_addr(2, 32'h4), 32'hFFFF_FFFE);
        write_reg(reg_addr(2, 32'h8), 32'h1);
        step(1);
        check_reg("ch2 count pre ovf", reg_addr(2, 32'h4), 32'hFFFF_FFFF);
        write_reg(reg_addr(2, 32'hC), 32'h1);
        check_reg("ch2 ovf beats w1c", reg_addr(2, 32'hC), 32'h1);
        check_reg("ch2 count reloaded", reg_addr(2, 32'h4), 32'h0);
        write_reg(reg_addr(2, 32'h8), 32'h0);
        write_reg(reg_addr(2, 32'hC), 32'h1);
        check_reg("ch2 status cleared", reg_addr(2, 32'hC), 32'h0);

        // ch2 COUNT write coincident with overflow
        write_reg(reg_addr(2, 32'h4), 32'hFFFF_FFFE);
        write_reg(reg_addr(2, 32'h8), 32'h1);
        step(1);
        check_reg("ch2 count pre ovf 2", reg_addr(2, 32'h4), 32'hFFFF_FFFF);
        write_reg(reg_addr(2, 32'h4), 32'h0000_1234);
        check_reg("ch2 count write wins", reg_addr(2, 32'h4), 32'h0000_1234);
        check_reg("ch2 no pending", reg_addr(2, 32'hC), 32'h0);
        write_reg(reg_addr(2, 32'h8), 32'h0);

        // ch0 and ch3 overflow, ch3 interrupt disabled
        write_reg(reg_addr(0, 32'h4), 32'hFFFF_FFFF);
        write_reg(reg_addr(3, 32'h4), 32'hFFFF_FFFF);
        write_reg(reg_addr(0, 32'h8), 32'h3);
        write_reg(reg_addr(3, 32'h8), 32'h1);
        step(1);
        check_reg("summary ch0 ch3", SUM, 32'h9);
        check("irq from ch0", 32'(irq), 32'h1);
        write_reg(reg_addr(0, 32'hC), 32'h1);
        check_reg("summary ch3 only", SUM, 32'h8);
        check("irq ch3 masked", 32'(irq), 32'h0);

        // async reset with pending and running channels
        write_reg(reg_addr(3, 32'h8), 32'h3);
        check("irq ch3 enabled", 32'(irq), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("irq async drop", 32'(irq), 32'h0);
        check_reg("summary in reset", SUM, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check_all_zero("after mid reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
# timer_bank

Memory-mapped bank of N independent up-counting timers on the CPU data bus in the peripheral address space. It is the parametrised successor of the single fixed timer. It adds per-channel prescalers, one-shot/auto-reload modes, write-1-to-clear interrupt status and a summary register. It drives a single level interrupt line to the CPU.

## Interface
- N_CH, 4, number of timer channels (1..8)
- CNT_W, 32, counter/reload width (1..32)
- PRESC_W, 8, prescaler width (1..16)
- BASE_ADDR, 32'h40000000, base of the register window; only addr[30:0] is decoded (bit 31 ignored)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (clock is clk)
- rd  in  1  read strobe
- wr  in  1  write strobe
- addr  in  32  byte address
- wdata  in  32  write data
- rdata  out  32  read data, combinational
- irq  out  1  OR over channels of (pending & ie)
- r_accessible  out  1  rd hit a mapped register, combinational
- w_accessible  out  1  wr hit a writable register, combinational

## Operation
- Channel c window is BASE + 0x10·c:
  - +0x0 RELOAD, RW.
  - +0x4 COUNT, RW.
  - +0x8 CTRL, RW: bit0 en, bit1 ie, bit2 oneshot, bits[8+PRESC_W-1:8] presc.
  - +0xC STATUS, bit0 pending; read returns pending, writing 1 clears it.
- SUMMARY at BASE + 0x10·N_CH, read-only. Returns pending bits of all channels, zero-extended. A write to it is unmapped.
- Reads are zero-extended from CNT_W/PRESC_W. Writes are truncated.
- Unmapped read: rdata = 32'hcdcdcdcd, r_accessible = 0.
- rd = 0: rdata = 0, r_accessible = 0. No latches.
- w_accessible = wr & hit on a writable register.
- Prescaler: per-channel pcnt counts 0..presc while en = 1. A tick occurs when pcnt == presc, and pcnt then returns to 0. presc = 0 gives a tick every cycle.
- On each tick, if COUNT != all-ones, COUNT increments by 1.
- On a tick with COUNT == all-ones (overflow):
  - COUNT <= RELOAD.
  - pending <= 1. This happens regardless of ie; ie only gates irq.
  - If oneshot = 1, en <= 0.
- en = 0 freezes COUNT and holds pcnt at 0.
- Any write to CTRL resets pcnt to 0.
- Simultaneous events, in priority order:
  - A bus write to COUNT overrides increment/reload in that cycle. No pending is set if the write and an overflow coincide.
  - A bus write to CTRL overrides the one-shot auto-clear of en.
  - An overflow setting pending beats a W1C clear of pending in the same cycle.
- Reset: all RELOAD, COUNT, CTRL, pcnt and pending are 0; irq = 0; w_accessible = r_accessible = 0 (no strobes asserted).
- Reset mid-count aborts immediately, asynchronously. No residual pending.

## Timing
- All state updates on posedge clk. Reset is asynchronous on negedge reset; release is synchronous to clk by the system.
- Write latency is 1 cycle: a register written at edge k reads back the new value from edge k onward.
- With presc = 0 and en = 1, COUNT written to X at edge k reads X+1 after edge k+1.
- Overflow period is (2^CNT_W − RELOAD) · (presc+1) cycles.
- irq is combinational from registers. It rises in the cycle after the overflow edge, and falls in the cycle after the W1C edge or after ie is cleared.
- There is no read side effect. Reading STATUS does not clear it.

## Structure
- Package timer_bank_pkg:
  - register offset constants (OFS_RELOAD, OFS_COUNT, OFS_CTRL, OFS_STATUS, stride 0x10)
  - CTRL bit positions
  - RDATA_UNMAPPED = 32'hcdcdcdcd
- Sub-module timer_channel holds one channel's RELOAD, COUNT, CTRL, pcnt and pending, with a decoded per-register write-enable interface.
- timer_bank generates N_CH instances of timer_channel and contains the address decode, read mux, SUMMARY and irq OR.

## Test plan
- Reset, then read all mapped registers → all 0. Read BASE+0x100 → 32'hcdcdcdcd, r_accessible = 0.
- CNT_W = 32, ch0:
  - Stimulus: RELOAD = 0xFFFFFFF0, COUNT = 0xFFFFFFFE, CTRL = 0x3.
  - Response: overflow on the 2nd edge; COUNT = 0xFFFFFFF0; irq high the next cycle.
  - Then write STATUS = 1 → irq low the next cycle.
- ch1 presc = 3, one-shot:
  - Stimulus: COUNT = all-ones − 1, CTRL = 0x305.
  - Response: increments every 4 cycles; overflow after 8 cycles; en reads 0; COUNT stays at RELOAD.
- Same-cycle events on ch2:
  - W1C coincident with overflow → pending stays 1.
  - COUNT write coincident with overflow → COUNT = written value, pending 0.
- Channels 0 and 3 overflow with ie = 0 on ch3 → SUMMARY = 0x9, irq driven only by ch0.
- Assert reset mid-count with pending set → irq drops asynchronously; all registers read 0 after release.
